// File: rtl/pong_pkg.sv
// pong_pkg: shared types and constants for the pong game-state controller.
//   state_t    : game phase (NEWGAME, PLAY, NEWBALL, OVER)
//   bcd_t      : one BCD digit
//   TXT_*      : bit positions inside the {score, logo, over} text enable mask
//   text_mask(): text enable mask shown while in a given phase
package pong_pkg;

  typedef enum logic [1:0] {
    NEWGAME = 2'd0,
    PLAY    = 2'd1,
    NEWBALL = 2'd2,
    OVER    = 2'd3
  } state_t;

  typedef logic [3:0] bcd_t;

  // Prefixed so they do not collide with the OVER state literal.
  localparam int TXT_SCORE = 2;
  localparam int TXT_LOGO  = 1;
  localparam int TXT_OVER  = 0;

  // The score layer is always on; the logo is shown only while waiting for
  // a new game and the "game over" banner only in OVER.
  function automatic logic [2:0] text_mask(input state_t s);
    logic [2:0] m;
    m            = '0;
    m[TXT_SCORE] = 1'b1;
    if (s == NEWGAME) m[TXT_LOGO] = 1'b1;
    if (s == OVER)    m[TXT_OVER] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// bcd2_counter: two-digit BCD up-counter that saturates at 99.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to 00 (wins over inc)
//   inc        : add one (ignored at 99)
//   tens, ones : registered BCD digits, always within 0..9
module bcd2_counter
  import pong_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output bcd_t tens,
  output bcd_t ones
);

  bcd_t tens_reg, tens_next;
  bcd_t ones_reg, ones_next;
  logic at_max;

  assign at_max = (tens_reg == 4'd9) && (ones_reg == 4'd9);

  always_comb begin
    tens_next = tens_reg;
    ones_next = ones_reg;
    if (clr) begin
      tens_next = 4'd0;
      ones_next = 4'd0;
    end else if (inc && !at_max) begin
      if (ones_reg == 4'd9) begin
        ones_next = 4'd0;
        tens_next = tens_reg + 4'd1;
      end else begin
        ones_next = ones_reg + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens_reg <= 4'd0;
      ones_reg <= 4'd0;
    end else begin
      tens_reg <= tens_next;
      ones_reg <= ones_next;
    end
  end

  assign tens = tens_reg;
  assign ones = ones_reg;

endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: game-state controller feeding the text overlay and playfield.
//   clk, rst_n      : pixel clock, asynchronous active-low reset
//   tick            : one pulse per video frame, paces the pause timer
//   btn[1:0]        : player buttons (level); any bit set counts as a press
//   hit1, hit2      : player 1 / player 2 scores (pulse, honoured in PLAY only)
//   miss            : ball left the field (pulse, honoured in PLAY only)
//   dig3..dig0      : P1 tens, P1 ones, P2 tens, P2 ones (BCD)
//   ball[4:0]       : balls remaining (bit 4 always 0)
//   text_en[2:0]    : {score, logo, over} layer enables
//   gra_still       : 1 freezes ball and paddles
// All outputs are registered with one cycle of latency.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int BALLS       = 3,
  parameter int TIMER_TICKS = 120,
  parameter int TIMER_W     = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [1:0] btn,
  input  logic       hit1,
  input  logic       hit2,
  input  logic       miss,
  output logic [3:0] dig3,
  output logic [3:0] dig2,
  output logic [3:0] dig1,
  output logic [3:0] dig0,
  output logic [4:0] ball,
  output logic [2:0] text_en,
  output logic       gra_still
);

  localparam logic [3:0]         BALLS_INIT = 4'(BALLS);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TIMER_TICKS);
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
  localparam logic [2:0]         TEXT_RST   = 3'b110;

  state_t             state_reg, state_next;
  logic [3:0]         ball_reg, ball_next;
  logic [TIMER_W-1:0] timer_reg, timer_next;
  logic [2:0]         text_en_reg, text_en_next;
  logic               gra_still_reg, gra_still_next;

  logic       pressed;
  logic       timer_done;
  logic       in_play;
  logic       score_clr;
  logic [1:0] score_inc;
  bcd_t [1:0] score_tens;
  bcd_t [1:0] score_ones;

  assign pressed    = (btn != 2'b00);
  assign timer_done = (timer_reg == '0);
  assign in_play    = (state_reg == PLAY);

  // Scores are cleared only when a new game actually starts, so the final
  // score stays on screen through OVER and the idle NEWGAME phase.
  assign score_clr = (state_reg == NEWGAME) && pressed;
  assign score_inc = {hit2, hit1} & {2{in_play}};

  // Index 0 is player 1, index 1 is player 2.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_score
      bcd2_counter u_score (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (score_clr),
        .inc   (score_inc[gi]),
        .tens  (score_tens[gi]),
        .ones  (score_ones[gi])
      );
    end
  endgenerate

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= NEWGAME;
      ball_reg      <= BALLS_INIT;
      timer_reg     <= '0;
      text_en_reg   <= TEXT_RST;
      gra_still_reg <= 1'b1;
    end else begin
      state_reg     <= state_next;
      ball_reg      <= ball_next;
      timer_reg     <= timer_next;
      text_en_reg   <= text_en_next;
      gra_still_reg <= gra_still_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      NEWGAME: if (pressed) state_next = PLAY;
      PLAY:    if (miss) state_next = (ball_reg > 4'd1) ? NEWBALL : OVER;
      NEWBALL: if (timer_done && pressed) state_next = PLAY;
      OVER:    if (timer_done) state_next = NEWGAME;
      default: state_next = NEWGAME;
    endcase
  end

  // Ball counter and pause timer.
  always_comb begin
    ball_next  = ball_reg;
    timer_next = timer_reg;
    // The load is checked first so it overrides a tick in the same cycle.
    if (in_play && miss) begin
      ball_next  = ball_reg - 4'd1;
      timer_next = TIMER_LOAD;
    end else if (tick && !timer_done) begin
      timer_next = timer_reg - TIMER_ONE;
    end
    if ((state_reg == NEWGAME && pressed) || (state_reg == OVER && timer_done)) begin
      ball_next = BALLS_INIT;
    end
  end

  // Output decode, taken from the next state so it lines up with the
  // registered state after the edge.
  always_comb begin
    text_en_next   = text_mask(state_next);
    gra_still_next = (state_next != PLAY);
  end

  assign dig3      = score_tens[0];
  assign dig2      = score_ones[0];
  assign dig1      = score_tens[1];
  assign dig0      = score_ones[1];
  assign ball      = {1'b0, ball_reg};
  assign text_en   = text_en_reg;
  assign gra_still = gra_still_reg;

endmodule

// File: tb/tb_pong_game_ctrl.sv
module tb_pong_game_ctrl;

  localparam int BALLS = 3;
  localparam int TICKS = 120;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic [1:0] btn = 2'b00;
  logic       hit1 = 1'b0;
  logic       hit2 = 1'b0;
  logic       miss = 1'b0;
  logic [3:0] dig3, dig2, dig1, dig0;
  logic [4:0] ball;
  logic [2:0] text_en;
  logic       gra_still;

  pong_game_ctrl #(.BALLS(BALLS), .TIMER_TICKS(TICKS), .TIMER_W(7)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .btn       (btn),
    .hit1      (hit1),
    .hit2      (hit2),
    .miss      (miss),
    .dig3      (dig3),
    .dig2      (dig2),
    .dig1      (dig1),
    .dig0      (dig0),
    .ball      (ball),
    .text_en   (text_en),
    .gra_still (gra_still)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: scores as plain integers, phase as its own small code.
  localparam int M_IDLE  = 0;  // waiting for a start press
  localparam int M_RUN   = 1;  // ball in play
  localparam int M_PAUSE = 2;  // between balls
  localparam int M_END   = 3;  // game over banner
  int m_phase, m_s1, m_s2, m_balls, m_pause;

  function automatic logic [24:0] dut_outs();
    return {dig3, dig2, dig1, dig0, ball, text_en, gra_still};
  endfunction

  function automatic logic [24:0] model_outs();
    logic [2:0] te;
    logic       gs;
    te = (m_phase == M_IDLE) ? 3'b110 : (m_phase == M_END) ? 3'b101 : 3'b100;
    gs = (m_phase != M_RUN);
    return {4'(m_s1 / 10), 4'(m_s1 % 10), 4'(m_s2 / 10), 4'(m_s2 % 10),
            5'(m_balls), te, gs};
  endfunction

  function automatic int sat_inc(input int s);
    return (s < 99) ? s + 1 : 99;
  endfunction

  task automatic model_reset();
    m_phase = M_IDLE; m_s1 = 0; m_s2 = 0; m_balls = BALLS; m_pause = 0;
  endtask

  task automatic model_step(input logic t, input logic [1:0] b,
                            input logic h1, input logic h2, input logic m);
    bit load;
    load = 0;
    case (m_phase)
      M_IDLE: if (b != 0) begin
        m_s1 = 0; m_s2 = 0; m_balls = BALLS; m_phase = M_RUN;
      end
      M_RUN: begin
        if (h1) m_s1 = sat_inc(m_s1);
        if (h2) m_s2 = sat_inc(m_s2);
        if (m) begin
          m_balls = m_balls - 1;
          load = 1;
          m_phase = (m_balls > 0) ? M_PAUSE : M_END;
        end
      end
      M_PAUSE: if (m_pause == 0 && b != 0) m_phase = M_RUN;
      default: if (m_pause == 0) begin
        m_phase = M_IDLE; m_balls = BALLS;
      end
    endcase
    if (load) m_pause = TICKS;
    else if (t && m_pause > 0) m_pause = m_pause - 1;
  endtask

  task automatic check(input string name, input logic [24:0] act, input logic [24:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic check_model(input string name);
    check(name, dut_outs(), model_outs());
  endtask

  // One clock cycle of stimulus; outputs are settled 1 time unit after the edge.
  task automatic step(input logic t, input logic [1:0] b,
                      input logic h1, input logic h2, input logic m);
    tick = t; btn = b; hit1 = h1; hit2 = h2; miss = m;
    @(posedge clk);
    #1;
    model_step(t, b, h1, h2, m);
  endtask

  typedef struct {
    logic       t;
    logic [1:0] b;
    logic       h1, h2, m;
    logic [15:0] dig;
    logic [4:0]  bl;
    logic [2:0]  te;
    logic        gs;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Starting from NEWGAME after reset.
    vecs[0] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 5'd3, 3'b110, 1'b1};
    vecs[1] = '{1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 16'h0000, 5'd3, 3'b100, 1'b0};
    vecs[2] = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 16'h0100, 5'd3, 3'b100, 1'b0};
    vecs[3] = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 16'h0101, 5'd3, 3'b100, 1'b0};
    vecs[4] = '{1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 16'h0202, 5'd3, 3'b100, 1'b0};
    vecs[5] = '{1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 16'h0302, 5'd3, 3'b100, 1'b0};
    // Hit with miss (and a tick, so the load must win over the decrement).
    vecs[6] = '{1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 16'h0402, 5'd2, 3'b100, 1'b1};
    vecs[7] = '{1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 16'h0402, 5'd2, 3'b100, 1'b1};
    vecs[8] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 16'h0402, 5'd2, 3'b100, 1'b1};

    // Reset, release, 10 idle cycles.
    model_reset();
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(0, 2'b00, 0, 0, 0);
      check_model("idle");
    end
    check("reset_state", dut_outs(), {16'h0000, 5'd3, 3'b110, 1'b1});

    // Table-driven vectors.
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].t, vecs[i].b, vecs[i].h1, vecs[i].h2, vecs[i].m);
      check($sformatf("vec%0d", i), dut_outs(),
            {vecs[i].dig, vecs[i].bl, vecs[i].te, vecs[i].gs});
    end

    // Pause with button held: 119 ticks keep NEWBALL, the 120th zeroes the
    // timer, the launch happens on the following cycle.
    for (int i = 0; i < 119; i++) step(1, 2'b10, 0, 0, 0);
    check("pause_119", 25'(gra_still), 25'(1'b1));
    step(1, 2'b10, 0, 0, 0);
    check("pause_120", 25'(gra_still), 25'(1'b1));
    check_model("pause_120_m");
    step(0, 2'b10, 0, 0, 0);
    check("launch", {22'd0, text_en, gra_still}, {22'd0, 3'b100, 1'b0});

    // P1 up to 12 (passing 09 -> 10), then P2 swept to 98 and saturated.
    while (m_s1 < 12) begin
      step(0, 2'b00, 1, 0, 0);
      check_model("p1_sweep");
    end
    check("p1_12", 25'({dig3, dig2}), 25'h12);
    while (m_s2 < 98) begin
      step(0, 2'b00, 0, 1, 0);
      check_model("p2_sweep");
    end
    check("p2_98", 25'({dig1, dig0}), 25'h98);
    for (int i = 0; i < 3; i++) step(0, 2'b00, 0, 1, 0);
    check("p2_sat", 25'({dig1, dig0}), 25'h99);

    // Remaining balls down to game over.
    step(0, 2'b00, 0, 0, 1);
    check("miss_ball1", 25'(ball), 25'd1);
    for (int i = 0; i < TICKS; i++) step(1, 2'b01, 0, 0, 0);
    step(0, 2'b01, 0, 0, 0);
    check_model("relaunch");
    step(0, 2'b00, 1, 0, 1);
    check("over_entry", {17'd0, ball, text_en}, {17'd0, 5'd0, 3'b101});
    check_model("over_entry_m");
    step(0, 2'b11, 1, 1, 1);
    check_model("over_ignore");
    for (int i = 0; i < TICKS; i++) step(1, 2'b00, 0, 0, 0);
    check("over_hold", {22'd0, text_en, gra_still}, {22'd0, 3'b101, 1'b1});
    step(0, 2'b00, 0, 0, 0);
    check_model("newgame_return");
    check("newgame_ball", {17'd0, ball, text_en}, {17'd0, 5'd3, 3'b110});
    step(0, 2'b00, 1, 1, 1);
    check_model("newgame_ignore");
    step(0, 2'b01, 0, 0, 0);
    check("scores_clr", 25'({dig3, dig2, dig1, dig0}), 25'h0);

    // Asynchronous reset in the middle of a pause (timer at 57).
    step(0, 2'b00, 0, 0, 1);
    for (int i = 0; i < TICKS - 57; i++) step(1, 2'b00, 0, 0, 0);
    check_model("pause_57");
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", dut_outs(), {16'h0000, 5'd3, 3'b110, 1'b1});
    model_reset();
    tick = 0; btn = 0; hit1 = 0; hit2 = 0; miss = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step(0, 2'b00, 0, 0, 0);
    check_model("post_reset");

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      logic       r_t, r_h1, r_h2, r_m;
      logic [1:0] r_b;
      r_t  = 1'($urandom_range(0, 1));
      r_b  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      r_h1 = ($urandom_range(0, 1) == 0);
      r_h2 = ($urandom_range(0, 2) == 0);
      r_m  = ($urandom_range(0, 149) == 0);
      step(r_t, r_b, r_h1, r_h2, r_m);
      check_model("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
